ram1k_bank_ctl: RTL and testbench
=================================

RAM1K_BANK_CTL -- requirements
Module: ram1k_bank_ctl

Interface
REQ-001 The block SHALL have parameter DW, default 36: data width, i.e. the number of parallel 1Kx1 ECL RAM chips in the bank.
REQ-002 The block SHALL have parameter RD_CYCLES, default 2 (legal range 1-15): clocks the bank is enabled before read data is sampled.
REQ-003 The block SHALL have parameter WP_CYCLES, default 2 (legal range 1-15): clocks nwrite is held low per write.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports req0/req1, input, 1 each: requester n wants a RAM cycle.
REQ-007 Ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-008 Ports addr0/addr1, input, 10 each: word address.
REQ-009 Ports wdata0/wdata1, input, DW each: write data.
REQ-010 Ports ack0/ack1, output, 1 each: one-clock completion pulse.
REQ-011 Port rdata, output, DW: read result, valid with ack and held until the next read ack.
REQ-012 Port busy, output, 1: high in every non-IDLE state.
REQ-013 Port perr, output, 1: read parity error, pulsed with ack.
REQ-014 Ports ram_addr (output, 10), ram_d (output, DW+P), ram_nen (output, 1, active-low enable), ram_nwrite (output, 1, active-low write) and ram_q (input, DW+P) SHALL connect to the RAM bank; P=1 with parity configured, else P=0.

Function
REQ-015 States SHALL be IDLE, READ, WSETUP, WPULSE, WHOLD and DONE.
REQ-016 In IDLE, at an edge with any req high, the controller SHALL register the winner's we, addr and wdata, then go to READ (we=0) or WSETUP (we=1).
REQ-017 Arbitration SHALL be round-robin: with both req high, grant goes to the port not served last; with one req high, that port is granted.
REQ-018 READ SHALL last RD_CYCLES clocks with ram_nen=0 and ram_nwrite=1; ram_q SHALL be captured into rdata at the edge leaving READ; the next state SHALL be DONE.
REQ-019 A write SHALL be sequenced as WSETUP (1 clock, nen=0, nwrite=1), then WPULSE (WP_CYCLES clocks, nen=0, nwrite=0), then WHOLD (1 clock, nen=0, nwrite=1), then DONE.
REQ-020 ram_addr and ram_d SHALL stay constant from the first non-IDLE clock through DONE.
REQ-021 ram_nwrite SHALL never be 0 while ram_nen is 1.
REQ-022 DONE SHALL last 1 clock, SHALL pulse the served port's ack, and SHALL then go to IDLE.
REQ-023 Read latency SHALL be RD_CYCLES+1 clocks from the granting edge to ack; write latency SHALL be WP_CYCLES+3 clocks.
REQ-024 Dropping req mid-operation SHALL NOT abort the cycle; ack SHALL still pulse.
REQ-025 A requester holding req high through ack SHALL be eligible again from IDLE.
REQ-026 The RD_CYCLES and WP_CYCLES counters SHALL be 4 bits, loaded at state entry, with no wrap-around.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, ram_nen=1, ram_nwrite=1, ram_addr=0, ram_d=0, ack0=ack1=0, rdata=0, busy=0, perr=0 and last-served=port 1 (so port 0 wins the first tie).
REQ-028 Reset asserted during WPULSE SHALL abort the write immediately; the stored contents are then undefined.

Configuration
REQ-029 The parity feature SHALL be controlled by the macro RAM1K_BANK_CTL_PARITY_EN.
REQ-030 With RAM1K_BANK_CTL_PARITY_EN defined: ram_d[DW] SHALL equal the XOR of wdata, and on read, perr SHALL pulse with ack when ram_q has odd XOR.
REQ-031 Without RAM1K_BANK_CTL_PARITY_EN: P=0 and perr SHALL be tied 0.

Structure
REQ-032 Package ram1k_pkg SHALL hold the state enum, RAM1K_AW=10 and the default RD_CYCLES/WP_CYCLES constants.
REQ-033 Sub-module ram1k_rr_arb (2-way round-robin, registered last-served pointer) SHALL be instantiated once.

Verification
REQ-034 Reset, then req0 read of addr 0x155 with ram_q model=0x123456789 -> ack0 exactly 3 clocks after the grant edge, rdata=0x123456789.
REQ-035 req1 write of addr 0x3FF, data 0xFFFFFFFFF -> nwrite low exactly 2 clocks, bracketed by 1 setup and 1 hold clock; ack1 5 clocks after grant; a following read returns 0xFFFFFFFFF.
REQ-036 req0 and req1 both held high for 4 transactions -> grants in order 0,1,0,1.
REQ-037 req0 dropped one clock after grant -> cycle completes, ack0 pulses once.
REQ-038 Reset asserted in the 1st WPULSE clock -> same-cycle nen=1, nwrite=1, busy=0; next request is served normally.
REQ-039 PARITY_EN build: read returning an odd-parity word -> perr=1 concurrent with ack; even-parity word -> perr=0.

Source files
------------

// File: rtl/ram1k_pkg.sv
// Shared types and constants for the 1Kx1 ECL RAM bank controller.
// Macro RAM1K_BANK_CTL_PARITY_EN adds one even-parity bit to every stored word.
package ram1k_pkg;

    localparam int RAM1K_AW            = 10;
    localparam int RAM1K_RD_CYCLES_DEF = 2;
    localparam int RAM1K_WP_CYCLES_DEF = 2;

`ifdef RAM1K_BANK_CTL_PARITY_EN
    localparam int RAM1K_P = 1;
`else
    localparam int RAM1K_P = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD,
        ST_DONE
    } ram1k_state_e;

endpackage

// File: rtl/ram1k_rr_arb.sv
// Two-way round-robin arbiter with a registered last-served pointer.
// On a tie the port that was not served last wins; after reset port 0 wins.
module ram1k_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last;

    // Pick the winner from the current requests and the last-served pointer.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_port  = (req0 & req1) ? ~last : req1;
    end

    // Remember who was served whenever a grant is actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (take && gnt_valid) begin
            last <= gnt_port;
        end
    end

endmodule

// File: rtl/ram1k_bank_ctl.sv
// Sequencer for a bank of DW parallel 1Kx1 ECL RAM chips shared by two requesters.
// Optional macro RAM1K_BANK_CTL_PARITY_EN: extra parity bit on ram_d/ram_q and perr.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | bank disabled, waiting for a request
// ST_READ   | bank enabled RD_CYCLES clocks, ram_q captured on exit
// ST_WSETUP | address/data setup, bank enabled, nwrite high
// ST_WPULSE | write pulse, nwrite low for WP_CYCLES clocks
// ST_WHOLD  | address/data hold, nwrite back high
// ST_DONE   | one-clock ack to the served port
module ram1k_bank_ctl
    import ram1k_pkg::*;
#(
    parameter int DW        = 36,
    parameter int RD_CYCLES = RAM1K_RD_CYCLES_DEF,
    parameter int WP_CYCLES = RAM1K_WP_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [RAM1K_AW-1:0]     addr0,
    input  logic [RAM1K_AW-1:0]     addr1,
    input  logic [DW-1:0]           wdata0,
    input  logic [DW-1:0]           wdata1,
    output logic                    ack0,
    output logic                    ack1,
    output logic [DW-1:0]           rdata,
    output logic                    busy,
    output logic                    perr,
    output logic [RAM1K_AW-1:0]     ram_addr,
    output logic [DW+RAM1K_P-1:0]   ram_d,
    output logic                    ram_nen,
    output logic                    ram_nwrite,
    input  logic [DW+RAM1K_P-1:0]   ram_q
);

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WP_LOAD = 4'(WP_CYCLES - 1);

    ram1k_state_e          state, nxt;
    logic [3:0]            cnt;
    logic                  lat_port;
    logic                  gnt_valid, gnt_port;
    logic                  sel_we;
    logic [RAM1K_AW-1:0]   sel_addr;
    logic [DW-1:0]         sel_wdata;
    logic                  take;
`ifdef RAM1K_BANK_CTL_PARITY_EN
    logic                  perr_q;
`endif

    assign take = (state == ST_IDLE);

    ram1k_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Route the winning requester's command onto the latch inputs.
    always_comb begin
        sel_we    = gnt_port ? we1    : we0;
        sel_addr  = gnt_port ? addr1  : addr0;
        sel_wdata = gnt_port ? wdata1 : wdata0;
    end

    // Next state and bank strobes; strobes are decoded straight from state so reset clears them at once.
    always_comb begin
        nxt        = state;
        ram_nen    = 1'b0;
        ram_nwrite = 1'b1;
        busy       = 1'b1;
        ack0       = 1'b0;
        ack1       = 1'b0;
        perr       = 1'b0;
        case (state)
            ST_IDLE: begin
                ram_nen = 1'b1;
                busy    = 1'b0;
                if (gnt_valid) nxt = sel_we ? ST_WSETUP : ST_READ;
            end
            ST_READ:   if (cnt == 4'd0) nxt = ST_DONE;
            ST_WSETUP: nxt = ST_WPULSE;
            ST_WPULSE: begin
                ram_nwrite = 1'b0;
                if (cnt == 4'd0) nxt = ST_WHOLD;
            end
            ST_WHOLD:  nxt = ST_DONE;
            ST_DONE: begin
                ack0 = ~lat_port;
                ack1 = lat_port;
`ifdef RAM1K_BANK_CTL_PARITY_EN
                perr = perr_q;
`endif
                nxt  = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    // Dwell down-counter: loaded on entry to READ/WPULSE, stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state != nxt) begin
            if (nxt == ST_READ)        cnt <= RD_LOAD;
            else if (nxt == ST_WPULSE) cnt <= WP_LOAD;
            else                       cnt <= '0;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Latch the granted command; address and data then stay frozen until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_port <= 1'b0;
            ram_addr <= '0;
            ram_d    <= '0;
        end else if (take && gnt_valid) begin
            lat_port <= gnt_port;
            ram_addr <= sel_addr;
`ifdef RAM1K_BANK_CTL_PARITY_EN
            ram_d    <= {^sel_wdata, sel_wdata};
`else
            ram_d    <= sel_wdata;
`endif
        end
    end

    // Capture read data (and its parity check) on the edge leaving READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
`ifdef RAM1K_BANK_CTL_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else if (state == ST_READ && cnt == 4'd0) begin
            rdata  <= ram_q[DW-1:0];
`ifdef RAM1K_BANK_CTL_PARITY_EN
            perr_q <= ^ram_q;
`endif
        end else if (state == ST_IDLE) begin
`ifdef RAM1K_BANK_CTL_PARITY_EN
            perr_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ram1k_bank_ctl.sv
// Directed bench for ram1k_bank_ctl with a behavioural 1K-word RAM bank model.
// Build with RAM1K_BANK_CTL_PARITY_EN defined to exercise the parity path as well.
module tb_ram1k_bank_ctl;
    import ram1k_pkg::*;

    localparam int DW = 36;
`ifdef RAM1K_BANK_CTL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [9:0]      addr0 = '0, addr1 = '0;
    logic [DW-1:0]   wdata0 = '0, wdata1 = '0;
    logic            ack0, ack1, busy, perr, ram_nen, ram_nwrite;
    logic [DW-1:0]   rdata;
    logic [9:0]      ram_addr;
    logic [DW+P-1:0] ram_d, ram_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram1k_bank_ctl #(.DW(DW), .RD_CYCLES(2), .WP_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .perr(perr),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_nen(ram_nen),
        .ram_nwrite(ram_nwrite), .ram_q(ram_q)
    );

    // RAM bank model: writes while enabled with nwrite low, plus a bench preload port.
    logic [DW+P-1:0] mem [0:1023];
    logic            pl_en = 1'b0;
    logic [9:0]      pl_addr = '0;
    logic [DW+P-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)                        mem[pl_addr] <= pl_data;
        else if (!ram_nen && !ram_nwrite) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW+P-1:0] word(input logic [DW-1:0] d);
`ifdef RAM1K_BANK_CTL_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic preload(input logic [9:0] a, input logic [DW+P-1:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // One transaction: cycle c counts clocks after the grant edge, sampled on the falling edge.
    task automatic do_op(input bit port, input bit we, input logic [9:0] a,
                         input logic [DW-1:0] d, input bit drop,
                         output int lat, output logic [7:0] nw_tr, output logic [7:0] nen_tr,
                         output int acks, output bit stable, output bit illegal,
                         output bit perr_at_ack, output logic [9:0] first_addr);
        logic [9:0] ref_addr;
        @(negedge clk);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        lat = -1; nw_tr = '0; nen_tr = '0; acks = 0; stable = 1'b1; illegal = 1'b0;
        perr_at_ack = 1'b0; first_addr = '0; ref_addr = '0;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (drop && c == 1) begin req0 = 1'b0; req1 = 1'b0; end
            if (c < 8) begin nw_tr[c] = ram_nwrite; nen_tr[c] = ram_nen; end
            if (ram_nen && !ram_nwrite) illegal = 1'b1;
            if (c == 1) begin ref_addr = ram_addr; first_addr = ram_addr; end
            else if (ram_addr !== ref_addr) stable = 1'b0;
            if (port ? ack1 : ack0) begin
                acks++;
                lat = c;
                perr_at_ack = perr;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        if (port ? ack1 : ack0) acks++;
    endtask

    int          lat, acks;
    logic [7:0]  nw_tr, nen_tr;
    bit          stable, illegal, pa;
    logic [9:0]  fa;
    logic [3:0]  order;
    int          ngr;
    bit          both;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nen", ram_nen, 1);
        chk("rst_nwrite", ram_nwrite, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", {ack0, ack1}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_perr", perr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_d", ram_d, 0);
        @(negedge clk);
        reset = 1'b0;

        // Read of 0x155 from port 0
        preload(10'h155, word(36'h123456789));
        do_op(1'b0, 1'b0, 10'h155, '0, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("rd_lat", lat, 3);
        chk("rd_data", rdata, 36'h123456789);
        chk("rd_addr", fa, 10'h155);
        chk("rd_nw", nw_tr, 8'h0E);
        chk("rd_nen", nen_tr & 8'h06, 0);
        chk("rd_acks", acks, 1);
        chk("rd_stable", stable, 1);
        chk("rd_perr", pa, 0);

        // Write all-ones to 0x3FF from port 1, then read it back
        do_op(1'b1, 1'b1, 10'h3FF, 36'hFFFFFFFFF, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("wr_lat", lat, 5);
        chk("wr_nw", nw_tr, 8'h32);
        chk("wr_nen", nen_tr & 8'h1E, 0);
        chk("wr_acks", acks, 1);
        chk("wr_stable", stable, 1);
        chk("wr_illegal", illegal, 0);
        chk("wr_mem", mem[10'h3FF], word(36'hFFFFFFFFF));
        do_op(1'b0, 1'b0, 10'h3FF, '0, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("rb_lat", lat, 3);
        chk("rb_data", rdata, 36'hFFFFFFFFF);
        chk("rb_perr", pa, 0);

        // Request dropped one clock after grant still completes
        do_op(1'b0, 1'b0, 10'h155, '0, 1'b1, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("drop_lat", lat, 3);
        chk("drop_acks", acks, 1);
        chk("drop_data", rdata, 36'h123456789);

        // Round-robin with both requesters held high from reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        we0 = 1'b0; we1 = 1'b0; addr0 = 10'h155; addr1 = 10'h3FF;
        req0 = 1'b1; req1 = 1'b1;
        order = '0; ngr = 0; both = 1'b0;
        for (int c = 0; c < 80 && ngr < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1'b1;
            if (ack0 || ack1) begin
                order[ngr] = ack1;
                ngr++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("arb_count", ngr, 4);
        chk("arb_order", order, 4'b1010);
        chk("arb_both", both, 0);
        repeat (3) @(negedge clk);

        // Reset during the first write-pulse clock aborts the write
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h0AA; wdata0 = 36'h5A5A5A5A5;
        @(posedge clk);
        #1 req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("wp_nwrite", ram_nwrite, 0);
        reset = 1'b1;
        #1;
        chk("wp_rst_nen", ram_nen, 1);
        chk("wp_rst_nwrite", ram_nwrite, 1);
        chk("wp_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(1'b0, 1'b0, 10'h155, '0, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rdata, 36'h123456789);

`ifdef RAM1K_BANK_CTL_PARITY_EN
        // Odd-parity stored word flags perr with ack; even does not
        preload(10'h010, {1'b0, 36'h000000001});
        preload(10'h011, {1'b1, 36'h000000001});
        do_op(1'b0, 1'b0, 10'h010, '0, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("par_odd_perr", pa, 1);
        chk("par_odd_data", rdata, 36'h1);
        do_op(1'b1, 1'b0, 10'h011, '0, 1'b0, lat, nw_tr, nen_tr, acks, stable, illegal, pa, fa);
        chk("par_even_perr", pa, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
